// File: rtl/vga_capture.sv
// vga_capture: locks onto an incoming VGA sync stream, measures line/frame
// totals and emits one write strobe per active pixel with its coordinates.
// Pixel data is aligned so that wr_en/wr_data appear two clocks after the
// vid_rgb pin sample that produced them.
module vga_capture #(
    parameter int H_ACT_START = 216,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        vid_hsync,
    input  logic        vid_vsync,
    input  logic [23:0] vid_rgb,
    output logic        wr_en,
    output logic [23:0] wr_data,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic        locked
);

    localparam logic [10:0] H_BEG  = 11'(H_ACT_START);
    localparam logic [11:0] H_END  = 12'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_ACT_START + H_ACTIVE - 1);
    localparam logic [9:0]  V_BEG  = 10'(V_ACT_START);
    localparam logic [10:0] V_END  = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_ACT_START + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        MEASURE = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // sync/data input stage plus one extra data stage so the pixel lines up
    // with the counters that describe it
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [23:0] rgb_q, pix_rgb_q;

    logic [10:0] h_cnt_q, h_cnt_d, h_total_q, h_total_d;
    logic [9:0]  v_cnt_q, v_cnt_d, v_total_q, v_total_d;
    logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    state_t      state_q, state_d;
    logic [1:0]  frames_q, frames_d;

    logic        wr_en_q, wr_en_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        frame_start_q, frame_start_d;
    logic        last_pix_q, last_pix_d;
    logic        frame_done_q, frame_done_d;

    logic        hs_rise, vs_rise;
    logic [10:0] h_meas;
    logic [9:0]  v_meas;
    logic        h_ok, v_ok, active;

    assign hs_rise = hs_q & ~hs_prev_q;
    assign vs_rise = vs_q & ~vs_prev_q;
    // counter value plus one is the length of the line/frame just ended
    assign h_meas  = h_cnt_q + 11'd1;
    assign v_meas  = v_cnt_q + 10'd1;
    assign h_ok    = {1'b0, h_total_q} >= H_END;
    assign v_ok    = {1'b0, v_meas} >= V_END;

    assign active = (state_q == CAPTURE) &&
                    (v_cnt_q >= V_BEG) && ({1'b0, v_cnt_q} < V_END) &&
                    (h_cnt_q >= H_BEG) && ({1'b0, h_cnt_q} < H_END);

    // input registers and rise-detect history
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            rgb_q     <= '0;
            pix_rgb_q <= '0;
        end else begin
            hs_q      <= vid_hsync;
            vs_q      <= vid_vsync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= vid_rgb;
            pix_rgb_q <= rgb_q;
        end
    end

    // position counters and line/frame length measurement
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        h_seen_d  = h_seen_q | hs_rise;
        v_seen_d  = v_seen_q | vs_rise;
        if (hs_rise)
            h_cnt_d = '0;
        else if (h_cnt_q != 11'h7FF)
            h_cnt_d = h_meas;
        // vsync wins when both rise together, so no extra line is counted
        if (vs_rise)
            v_cnt_d = '0;
        else if (hs_rise && v_cnt_q != 10'h3FF)
            v_cnt_d = v_meas;
        // the first rise after reset has no predecessor to measure from
        if (hs_rise && h_seen_q)
            h_total_d = h_meas;
        if (vs_rise && v_seen_q)
            v_total_d = v_meas;
    end

    // lock FSM; frames_q counts frame boundaries seen while measuring so
    // capture needs two complete, consistent frames before it starts
    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        case (state_q)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d  = MEASURE;
                    frames_d = 2'd1;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    if (frames_q == 2'd2 && v_seen_q && v_meas == v_total_q && h_ok && v_ok)
                        state_d = CAPTURE;
                    else if (frames_q != 2'd2)
                        frames_d = frames_q + 2'd1;
                end
            end
            CAPTURE: begin
                if ((vs_rise && v_meas != v_total_q) || (hs_rise && h_meas != h_total_q)) begin
                    state_d  = MEASURE;
                    frames_d = vs_rise ? 2'd1 : 2'd0;
                end
            end
            default: begin
                state_d  = WAIT_VS;
                frames_d = 2'd0;
            end
        endcase
    end

    // output write port; coordinates and data hold between strobes
    always_comb begin
        wr_en_d       = active;
        wr_data_d     = wr_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = active && h_cnt_q == H_BEG && v_cnt_q == V_BEG;
        last_pix_d    = active && h_cnt_q == H_LAST && v_cnt_q == V_LAST;
        frame_done_d  = last_pix_q;
        if (active) begin
            wr_data_d = pix_rgb_q;
            pix_x_d   = h_cnt_q - H_BEG;
            pix_y_d   = v_cnt_q - V_BEG;
        end
    end

    // state registers
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            state_q       <= WAIT_VS;
            frames_q      <= 2'd0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            last_pix_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            state_q       <= state_d;
            frames_q      <= frames_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            last_pix_q    <= last_pix_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = (state_q == CAPTURE);

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scaled-down VGA timing (32 samples x 10 lines, active
// 16x4 at offset 8/3) driven frame by frame from a vector table, plus
// hand-written reset-abort sequence. A negedge monitor models the expected
// pixel stream (ramp data = sample index within the line).
module tb_vga_capture;

    localparam int H_S = 8;
    localparam int H_A = 16;
    localparam int V_S = 3;
    localparam int V_A = 4;
    localparam int HS  = 4;
    localparam int VS  = 2;
    localparam int FL  = 10;

    logic        sclk, s_rst_n, vid_hsync, vid_vsync;
    logic [23:0] vid_rgb;
    logic        wr_en, frame_start, frame_done, locked;
    logic [23:0] wr_data;
    logic [10:0] pix_x, h_total;
    logic [9:0]  pix_y, v_total;

    vga_capture #(.H_ACT_START(H_S), .H_ACTIVE(H_A), .V_ACT_START(V_S), .V_ACTIVE(V_A)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
        .vid_rgb(vid_rgb), .wr_en(wr_en), .wr_data(wr_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_done(frame_done), .h_total(h_total),
        .v_total(v_total), .locked(locked)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        int hlen;
        int short_line;
        int short_len;
        int exp_locked;
        int exp_wr;
        int exp_fs;
        int exp_fd;
        int exp_ht;
        int exp_vt;
    } frame_vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // monitor state
    int wr_cnt = 0, fs_cnt = 0, fd_cnt = 0;
    int pix_err = 0, seq_err = 0, hold_err = 0;
    int ex = 0, ey = 0;
    logic        prev_rst = 1'b0, prev_last = 1'b0;
    logic [23:0] prev_data = '0;
    logic [10:0] prev_x = '0;
    logic [9:0]  prev_y = '0;

    // pixel-stream model: coordinates, ramp data, frame pulses, hold behaviour
    always @(negedge sclk) begin
        prev_rst  <= s_rst_n;
        prev_data <= wr_data;
        prev_x    <= pix_x;
        prev_y    <= pix_y;
        prev_last <= wr_en && pix_x == 11'(H_A - 1) && pix_y == 10'(V_A - 1);
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (frame_start) fs_cnt <= fs_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (s_rst_n && wr_en) begin
            if (frame_start) begin
                if (pix_x != 11'd0 || pix_y != 10'd0 || wr_data != 24'(H_S))
                    pix_err <= pix_err + 1;
                ex <= 1;
                ey <= 0;
            end else begin
                if (pix_x != 11'(ex) || pix_y != 10'(ey) || wr_data != 24'(ex + H_S))
                    pix_err <= pix_err + 1;
                if (ex == H_A - 1) begin
                    ex <= 0;
                    ey <= ey + 1;
                end else begin
                    ex <= ex + 1;
                end
            end
        end
        if (s_rst_n && prev_rst &&
            (frame_start != (wr_en && pix_x == 11'd0 && pix_y == 10'd0) || frame_done != prev_last))
            seq_err <= seq_err + 1;
        if (s_rst_n && prev_rst && !wr_en &&
            (wr_data != prev_data || pix_x != prev_x || pix_y != prev_y))
            hold_err <= hold_err + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // drive lines l0..l1 of a frame; vsync and hsync rise together at line 0
    task automatic drive_lines(input int hlen, input int l0, input int l1,
                               input int sl, input int slen);
        for (int l = l0; l <= l1; l++) begin
            int len;
            len = (l == sl) ? slen : hlen;
            for (int s = 0; s < len; s++) begin
                @(negedge sclk);
                vid_hsync = (s < HS);
                vid_vsync = (l < VS);
                vid_rgb   = 24'(s);
            end
        end
    endtask

    task automatic run_frame(input frame_vec_t v, input string tag);
        int w0, f0, d0, e0;
        w0 = wr_cnt; f0 = fs_cnt; d0 = fd_cnt;
        e0 = pix_err + seq_err + hold_err;
        drive_lines(v.hlen, 0, FL - 1, v.short_line, v.short_len);
        chk({tag, " locked"},      int'(locked),  v.exp_locked);
        chk({tag, " wr_en count"}, wr_cnt - w0,   v.exp_wr);
        chk({tag, " frame_start"}, fs_cnt - f0,   v.exp_fs);
        chk({tag, " frame_done"},  fd_cnt - d0,   v.exp_fd);
        chk({tag, " h_total"},     int'(h_total), v.exp_ht);
        chk({tag, " v_total"},     int'(v_total), v.exp_vt);
        chk({tag, " pixel model errors"}, pix_err + seq_err + hold_err - e0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " wr_en"},       int'(wr_en), 0);
        chk({tag, " frame_start"}, int'(frame_start), 0);
        chk({tag, " frame_done"},  int'(frame_done), 0);
        chk({tag, " locked"},      int'(locked), 0);
        chk({tag, " wr_data"},     int'(wr_data), 0);
        chk({tag, " pix_x"},       int'(pix_x), 0);
        chk({tag, " pix_y"},       int'(pix_y), 0);
        chk({tag, " h_total"},     int'(h_total), 0);
        chk({tag, " v_total"},     int'(v_total), 0);
    endtask

    frame_vec_t vecs[11];
    frame_vec_t fv;
    int w0;

    initial begin
        //             hlen sl slen lk  wr fs fd  ht  vt
        vecs[0]  = '{32, -1,  0, 0,  0, 0, 0, 32,  0};  // first vsync: WAIT_VS -> MEASURE
        vecs[1]  = '{32, -1,  0, 0,  0, 0, 0, 32, 10};  // first v_total measurement
        vecs[2]  = '{32, -1,  0, 1, 64, 1, 1, 32, 10};  // locks at third vsync, full frame
        vecs[3]  = '{32,  5, 28, 0, 48, 1, 0, 32, 10};  // short active line aborts capture
        vecs[4]  = '{32, -1,  0, 0,  0, 0, 0, 32, 10};
        vecs[5]  = '{32, -1,  0, 0,  0, 0, 0, 32, 10};
        vecs[6]  = '{32, -1,  0, 1, 64, 1, 1, 32, 10};  // relocked after two good frames
        vecs[7]  = '{20, -1,  0, 0,  0, 0, 0, 20, 10};  // line too short for active window
        vecs[8]  = '{20, -1,  0, 0,  0, 0, 0, 20, 10};
        vecs[9]  = '{20, -1,  0, 0,  0, 0, 0, 20, 10};
        vecs[10] = '{20, -1,  0, 0,  0, 0, 0, 20, 10};

        s_rst_n = 1'b0; vid_hsync = 1'b0; vid_vsync = 1'b0; vid_rgb = '0;
        repeat (3) @(negedge sclk);
        chk_zero("reset");
        #2 s_rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_frame(vecs[i], $sformatf("frame%0d", i + 1));

        // reset mid-frame while capturing, then relock
        #2 s_rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        #2 s_rst_n = 1'b1;
        fv = '{32, -1, 0, 0, 0, 0, 0, 32, 0};   run_frame(fv, "rA");
        fv = '{32, -1, 0, 0, 0, 0, 0, 32, 10};  run_frame(fv, "rB");
        fv = '{32, -1, 0, 1, 64, 1, 1, 32, 10}; run_frame(fv, "rC");
        w0 = wr_cnt;
        drive_lines(32, 0, 4, -1, 0);
        chk("rD pre-reset wr_en count", wr_cnt - w0, 2 * H_A);
        #2 s_rst_n = 1'b0;
        #1 chk_zero("rD async reset");
        w0 = wr_cnt;
        drive_lines(32, 5, 5, -1, 0);
        chk_zero("rD held reset");
        chk("rD wr_en in reset", wr_cnt - w0, 0);
        #2 s_rst_n = 1'b1;
        w0 = wr_cnt;
        drive_lines(32, 6, FL - 1, -1, 0);
        chk("rD wr_en after release", wr_cnt - w0, 0);
        fv = '{32, -1, 0, 0, 0, 0, 0, 32, 0};   run_frame(fv, "rE");
        fv = '{32, -1, 0, 0, 0, 0, 0, 32, 10};  run_frame(fv, "rF");
        fv = '{32, -1, 0, 1, 64, 1, 1, 32, 10}; run_frame(fv, "rG");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
